// File: rtl/deck_ctrl_pkg.sv
// rtl/deck_ctrl_pkg.sv - shared constants, state encoding and card helpers for deck_ctrl
package deck_ctrl_pkg;

  localparam int          DECK_SIZE    = 52;
  localparam int          RANKS        = 13;
  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_PICK,
    ST_SWAP1,
    ST_SWAP2,
    ST_READY
  } state_t;

  // Blackjack value indexed by rank (card_id mod 13); ace counts as 11.
  localparam logic [7:0] RANK_VALUE [RANKS] = '{
    8'd11, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
    8'd8,  8'd9, 8'd10, 8'd10, 8'd10, 8'd10
  };

  function automatic logic [7:0] card_value(input logic [5:0] id);
    return RANK_VALUE[4'(id % 6'(RANKS))];
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/deck_ram.sv
// rtl/deck_ram.sv - 52x6 deck store, one synchronous write port, two asynchronous read ports
module deck_ram
  import deck_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       i_we,
  input  logic [5:0] i_waddr,
  input  logic [5:0] i_wdata,
  input  logic [5:0] i_raddr_a,
  input  logic [5:0] i_raddr_b,
  output logic [5:0] o_rdata_a,
  output logic [5:0] o_rdata_b
);

  logic [5:0] r_mem [DECK_SIZE];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/deck_ctrl.sv
// rtl/deck_ctrl.sv - deck fill, LFSR Fisher-Yates shuffle and round-robin card dealer
module deck_ctrl
  import deck_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mix_cards,
  input  logic [15:0] seed,
  input  logic        req_p,
  input  logic        req_d,
  output logic        gnt_p,
  output logic        gnt_d,
  output logic [5:0]  card_id,
  output logic [7:0]  card_val,
  output logic        shuffle_ok,
  output logic        deck_empty
);

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_k, r_i, r_ptr, r_tmp, r_card_id;
  logic [7:0]  r_card_val;
  logic [15:0] r_lfsr, w_lfsr_step;
  logic        r_rr, r_gnt_p, r_gnt_d;
  logic [5:0]  w_j, w_raddr_a, w_rd_a, w_rd_b, w_waddr, w_wdata;
  logic        w_we, w_grant_p, w_grant_d;

  // The LFSR only moves in PICK, so it still holds j throughout SWAP1/SWAP2.
  assign w_lfsr_step = lfsr_next(r_lfsr);
  assign w_j         = (r_state == ST_PICK) ? w_lfsr_step[5:0] : r_lfsr[5:0];
  assign w_raddr_a   = (r_state == ST_READY) ? r_ptr : r_i;

  deck_ram u_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_raddr_a),
    .i_raddr_b (w_j),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_k;
    w_wdata     = r_k;
    w_grant_p   = 1'b0;
    w_grant_d   = 1'b0;
    if (mix_cards) begin
      w_state_nxt = ST_INIT;
    end else begin
      case (r_state)
        ST_INIT: begin
          w_we = 1'b1;
          if (r_k == 6'(DECK_SIZE - 1)) w_state_nxt = ST_PICK;
        end
        ST_PICK: begin
          if (w_j <= r_i) w_state_nxt = ST_SWAP1;
        end
        ST_SWAP1: begin
          w_we        = 1'b1;
          w_waddr     = r_i;
          w_wdata     = w_rd_b;
          w_state_nxt = ST_SWAP2;
        end
        ST_SWAP2: begin
          w_we        = 1'b1;
          w_waddr     = w_j;
          w_wdata     = r_tmp;
          w_state_nxt = (r_i == 6'd1) ? ST_READY : ST_PICK;
        end
        ST_READY: begin
          // r_rr=0 favours the player when both request.
          if (r_ptr != 6'(DECK_SIZE)) begin
            if (req_p && (!req_d || !r_rr)) w_grant_p = 1'b1;
            else if (req_d)                 w_grant_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_i        <= '0;
      r_ptr      <= '0;
      r_tmp      <= '0;
      r_lfsr     <= LFSR_DEFAULT;
      r_rr       <= 1'b0;
      r_gnt_p    <= 1'b0;
      r_gnt_d    <= 1'b0;
      r_card_id  <= '0;
      r_card_val <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt_p <= w_grant_p;
      r_gnt_d <= w_grant_d;
      if (mix_cards) begin
        r_k    <= '0;
        r_ptr  <= '0;
        r_rr   <= 1'b0;
        r_lfsr <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
      end else begin
        case (r_state)
          ST_INIT: begin
            r_k <= r_k + 6'd1;
            if (r_k == 6'(DECK_SIZE - 1)) r_i <= 6'(DECK_SIZE - 1);
          end
          ST_PICK:  r_lfsr <= w_lfsr_step;
          ST_SWAP1: r_tmp  <= w_rd_a;
          ST_SWAP2: if (r_i != 6'd1) r_i <= r_i - 6'd1;
          default: ;
        endcase
        if (w_grant_p || w_grant_d) begin
          r_card_id  <= w_rd_a;
          r_card_val <= card_value(w_rd_a);
          r_ptr      <= r_ptr + 6'd1;
          r_rr       <= w_grant_p;
        end
      end
    end
  end

  assign gnt_p      = r_gnt_p;
  assign gnt_d      = r_gnt_d;
  assign card_id    = r_card_id;
  assign card_val   = r_card_val;
  assign shuffle_ok = (r_state == ST_READY);
  assign deck_empty = (r_state == ST_READY) && (r_ptr == 6'(DECK_SIZE));

endmodule

// File: tb/tb_deck_ctrl.sv
// tb/tb_deck_ctrl.sv - directed self-checking bench for deck_ctrl
module tb_deck_ctrl;

  logic        clk = 1'b0;
  logic        reset, mix_cards, req_p, req_d;
  logic [15:0] seed;
  logic        gnt_p, gnt_d, shuffle_ok, deck_empty;
  logic [5:0]  card_id;
  logic [7:0]  card_val;

  int checks = 0;
  int errors = 0;
  int exp_deck [52];
  int exp_cycles;
  int seen [64];
  int val_of [64];

  always #5 clk = ~clk;

  deck_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mix_cards  (mix_cards),
    .seed       (seed),
    .req_p      (req_p),
    .req_d      (req_d),
    .gnt_p      (gnt_p),
    .gnt_d      (gnt_d),
    .card_id    (card_id),
    .card_val   (card_val),
    .shuffle_ok (shuffle_ok),
    .deck_empty (deck_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_val(input int id);
    int r;
    r = id % 13;
    if (r == 0) return 11;
    if (r < 10) return r + 1;
    return 10;
  endfunction

  // Reference Fisher-Yates with LFSR rejection sampling plus its cycle cost.
  task automatic build_model(input logic [15:0] s);
    logic [15:0] l;
    int d [52];
    int j, t;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    for (int k = 0; k < 52; k++) d[k] = k;
    exp_cycles = 52;
    for (int i = 51; i >= 1; i--) begin
      do begin
        l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        j = int'(l[5:0]);
        exp_cycles++;
      end while (j > i);
      exp_cycles += 2;
      t = d[i]; d[i] = d[j]; d[j] = t;
    end
    exp_deck = d;
  endtask

  task automatic do_mix(input logic [15:0] s);
    seed = s;
    mix_cards = 1'b1;
    tick();
    mix_cards = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    int grants;
    n = 0;
    grants = 0;
    while (!shuffle_ok && n < 5000) begin
      tick();
      n++;
      if (gnt_p || gnt_d) grants++;
    end
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_no_grant_while_shuffling"}, 32'(grants), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    reset = 1'b1; mix_cards = 1'b0; seed = 16'h0000; req_p = 1'b1; req_d = 1'b1;
    repeat (3) tick();
    chk("rst_gnt_p", 32'(gnt_p), 32'd0);
    chk("rst_gnt_d", 32'(gnt_d), 32'd0);
    chk("rst_card_id", 32'(card_id), 32'd0);
    chk("rst_card_val", 32'(card_val), 32'd0);
    chk("rst_shuffle_ok", 32'(shuffle_ok), 32'd0);
    chk("rst_deck_empty", 32'(deck_empty), 32'd0);
    reset = 1'b0;
    bad = 0;
    repeat (8) begin
      tick();
      if (gnt_p || gnt_d || shuffle_ok) bad++;
    end
    chk("idle_no_grant", 32'(bad), 32'd0);
    req_p = 1'b0; req_d = 1'b0;

    // Full deal with alternating single-cycle requests, seed 1.
    build_model(16'h0001);
    do_mix(16'h0001);
    wait_ready("mix1");
    for (int i = 0; i < 64; i++) begin seen[i] = 0; val_of[i] = -1; end
    for (int n = 0; n < 52; n++) begin
      req_p = (n % 2 == 0);
      req_d = (n % 2 == 1);
      tick();
      chk("alt_gnt_p", 32'(gnt_p), 32'(n % 2 == 0));
      chk("alt_gnt_d", 32'(gnt_d), 32'(n % 2 == 1));
      chk("alt_card_id", 32'(card_id), 32'(exp_deck[n]));
      chk("alt_card_val", 32'(card_val), 32'(ref_val(exp_deck[n])));
      seen[card_id]++;
      val_of[card_id] = int'(card_val);
    end
    chk("deck_empty_after_52", 32'(deck_empty), 32'd1);
    bad = 0;
    for (int i = 0; i < 52; i++) if (seen[i] != 1) bad++;
    chk("ids_once_each", 32'(bad), 32'd0);
    chk("val_id0", 32'(val_of[0]), 32'd11);
    chk("val_id9", 32'(val_of[9]), 32'd10);
    chk("val_id12", 32'(val_of[12]), 32'd10);
    chk("val_id13", 32'(val_of[13]), 32'd11);
    chk("val_id51", 32'(val_of[51]), 32'd10);
    req_p = 1'b1; req_d = 1'b0;
    tick();
    chk("empty_no_grant", 32'(gnt_p | gnt_d), 32'd0);
    chk("empty_still", 32'(deck_empty), 32'd1);
    req_p = 1'b0;

    // Round-robin with both held high, then mix after 10 grants.
    do_mix(16'h0001);
    wait_ready("mix2");
    req_p = 1'b1; req_d = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("rr_gnt_p", 32'(gnt_p), 32'(n % 2 == 0));
      chk("rr_gnt_d", 32'(gnt_d), 32'(n % 2 == 1));
      chk("rr_card_id", 32'(card_id), 32'(exp_deck[n]));
    end
    build_model(16'h0000);
    do_mix(16'h0000);
    chk("mix_wins_no_grant", 32'(gnt_p | gnt_d), 32'd0);
    chk("mix_drops_ok", 32'(shuffle_ok), 32'd0);
    req_d = 1'b0;
    wait_ready("mix3");
    bad = 0;
    for (int n = 0; n < 52; n++) begin
      tick();
      if (!gnt_p || gnt_d || card_id != 6'(exp_deck[n])) bad++;
    end
    chk("redeal_52_cards", 32'(bad), 32'd0);
    chk("redeal_empty", 32'(deck_empty), 32'd1);
    req_p = 1'b0;

    // Reset in PICK: the 52 INIT edges are done, so the FSM is in PICK.
    do_mix(16'h0001);
    repeat (52) tick();
    chk("pick_not_ready", 32'(shuffle_ok), 32'd0);
    reset = 1'b1; req_p = 1'b1; req_d = 1'b1;
    tick();
    chk("rst_pick_ok", 32'(shuffle_ok), 32'd0);
    chk("rst_pick_id", 32'(card_id), 32'd0);
    chk("rst_pick_val", 32'(card_val), 32'd0);
    chk("rst_pick_empty", 32'(deck_empty), 32'd0);
    reset = 1'b0;
    bad = 0;
    repeat (60) begin
      tick();
      if (gnt_p || gnt_d || shuffle_ok) bad++;
    end
    chk("after_rst_pick_idle", 32'(bad), 32'd0);
    req_p = 1'b0; req_d = 1'b0;

    // Reset in the cycle a grant is shown.
    build_model(16'h0001);
    do_mix(16'h0001);
    wait_ready("mix4");
    req_p = 1'b1;
    tick();
    chk("pre_rst_gnt_p", 32'(gnt_p), 32'd1);
    chk("pre_rst_card", 32'(card_id), 32'(exp_deck[0]));
    reset = 1'b1;
    tick();
    chk("rst_gnt_gnt_p", 32'(gnt_p), 32'd0);
    chk("rst_gnt_id", 32'(card_id), 32'd0);
    chk("rst_gnt_val", 32'(card_val), 32'd0);
    chk("rst_gnt_ok", 32'(shuffle_ok), 32'd0);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (gnt_p || gnt_d || shuffle_ok) bad++;
    end
    chk("after_rst_gnt_idle", 32'(bad), 32'd0);
    req_p = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
